banco_ram4: RTL and testbench

Four-word register bank that sits directly downstream of the 1-to-4 write demultiplexer in the memory path. A single write request is routed into one of four word registers by a one-hot load enable. Reads come out of a registered read port. A built-in clear sequencer walks all four words back to a known value.

---
 rtl/banco_ram4_pkg.sv | 9 +
 rtl/banco_demux_we.sv | 10 +
 rtl/banco_ram4.sv | 74 +++++++
 tb/tb_banco_ram4.sv | 129 ++++++++++++
 4 files changed

// File: rtl/banco_ram4_pkg.sv
// banco_ram4_pkg: shared constants and FSM state type for the four-word register bank
package banco_ram4_pkg;
  localparam int ENDERECO_W = 2;
  localparam int NUM_PALAVRAS = 4;
  typedef enum logic {
    ESTADO_OCIOSO = 1'b0,
    ESTADO_LIMPANDO = 1'b1
  } estado_t;
endpackage

// File: rtl/banco_demux_we.sv
// banco_demux_we: 1-to-4 write-enable demux (en, sel -> one-hot we, all zero when en is low)
module banco_demux_we
  import banco_ram4_pkg::*;
(
  input  logic                    en,
  input  logic [ENDERECO_W-1:0]   sel,
  output logic [NUM_PALAVRAS-1:0] we
);
  always_comb we = en ? NUM_PALAVRAS'(1) << sel : '0;
endmodule

// File: rtl/banco_ram4.sv
// banco_ram4: four-word register bank (write handshake, registered read port, clear sequencer)
module banco_ram4
  import banco_ram4_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  escrita_valida,
  output logic                  escrita_pronta,
  input  logic [ENDERECO_W-1:0] endereco_escrita,
  input  logic [WIDTH-1:0]      dado_escrita,
  input  logic                  leitura_en,
  input  logic [ENDERECO_W-1:0] endereco_leitura,
  output logic [WIDTH-1:0]      dado_lido,
  output logic                  dado_lido_valido,
  input  logic                  limpar,
  output logic                  ocupado
);
  estado_t                 estado, estado_nx;
  logic [ENDERECO_W-1:0]   cnt, cnt_nx, sel_we;
  logic [WIDTH-1:0]        palavra [NUM_PALAVRAS];
  logic [WIDTH-1:0]        dado_we;
  logic [NUM_PALAVRAS-1:0] we;
  logic                    limpando, en_we;
  assign limpando       = estado == ESTADO_LIMPANDO;
  assign ocupado        = limpando;
  assign escrita_pronta = !limpando && !limpar;
  assign en_we          = limpando || (escrita_valida && escrita_pronta);
  assign sel_we         = limpando ? cnt : endereco_escrita;
  assign dado_we        = limpando ? CLEAR_VALUE : dado_escrita;
  banco_demux_we u_demux (
    .en (en_we),
    .sel(sel_we),
    .we (we)
  );
  always_comb begin
    estado_nx = estado;
    cnt_nx    = cnt;
    if (limpando) begin
      cnt_nx    = cnt + 1'b1;
      estado_nx = cnt == '1 ? ESTADO_OCIOSO : ESTADO_LIMPANDO;
    end else if (limpar) begin
      cnt_nx    = '0;
      estado_nx = ESTADO_LIMPANDO;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= ESTADO_OCIOSO;
      cnt    <= '0;
    end else begin
      estado <= estado_nx;
      cnt    <= cnt_nx;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PALAVRAS; i++) palavra[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PALAVRAS; i++) if (we[i]) palavra[i] <= dado_we;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dado_lido        <= '0;
      dado_lido_valido <= 1'b0;
    end else begin
      dado_lido_valido <= leitura_en;
      if (leitura_en) dado_lido <= palavra[endereco_leitura];
    end
  end
endmodule

// File: tb/tb_banco_ram4.sv
// tb_banco_ram4: randomized self-checking bench for banco_ram4 against a behavioural model
module tb_banco_ram4;
  localparam logic [7:0] CV = 8'h0F;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       escrita_valida = 1'b0, escrita_pronta;
  logic [1:0] endereco_escrita = '0, endereco_leitura = '0;
  logic [7:0] dado_escrita = '0, dado_lido;
  logic       leitura_en = 1'b0, dado_lido_valido;
  logic       limpar = 1'b0, ocupado;
  logic [7:0] mem [4];
  logic [7:0] exp_lido;
  logic       exp_valido;
  int         clear_left;
  int         n_checks = 0, n_fail = 0;
  banco_ram4 #(.WIDTH(8), .CLEAR_VALUE(CV)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .escrita_valida  (escrita_valida),
    .escrita_pronta  (escrita_pronta),
    .endereco_escrita(endereco_escrita),
    .dado_escrita    (dado_escrita),
    .leitura_en      (leitura_en),
    .endereco_leitura(endereco_leitura),
    .dado_lido       (dado_lido),
    .dado_lido_valido(dado_lido_valido),
    .limpar          (limpar),
    .ocupado         (ocupado)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    exp_lido = '0;
    exp_valido = 1'b0;
    clear_left = 0;
  endtask
  task automatic cyc(input logic v, input logic [1:0] wa, input logic [7:0] wd,
                     input logic re, input logic [1:0] ra, input logic lim);
    escrita_valida = v; endereco_escrita = wa; dado_escrita = wd;
    leitura_en = re; endereco_leitura = ra; limpar = lim;
    #1;
    check("escrita_pronta", escrita_pronta, clear_left == 0 && !lim);
    @(posedge clock);
    exp_valido = re;
    if (re) exp_lido = mem[ra];
    if (clear_left > 0) begin
      mem[4 - clear_left] = CV;
      clear_left--;
    end else if (lim) clear_left = 4;
    else if (v) mem[wa] = wd;
    #1;
    check("dado_lido", dado_lido, exp_lido);
    check("dado_lido_valido", dado_lido_valido, exp_valido);
    check("ocupado", ocupado, clear_left > 0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    escrita_valida = 0; leitura_en = 0; limpar = 0;
    #1;
    model_reset();
    check("rst_ocupado", ocupado, 0);
    check("rst_dado_lido", dado_lido, 0);
    check("rst_valido", dado_lido_valido, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    model_reset();
    do_reset();
    #1;
    check("post_rst_pronta", escrita_pronta, 1);
    for (int a = 0; a < 4; a++) begin
      cyc(0, 0, 0, 1, 2'(a), 0);
      check("rst_read", dado_lido, 0);
    end
    for (int a = 0; a < 4; a++) cyc(1, 2'(a), 8'(8'h11 * (a + 1)), 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      cyc(0, 0, 0, 1, 2'(a), 0);
      check("wr_rd_all", dado_lido, 8'(8'h11 * (a + 1)));
    end
    cyc(1, 2, 8'hAA, 1, 2, 0);
    check("rbw_old", dado_lido, 8'h33);
    cyc(0, 0, 0, 1, 2, 0);
    check("rbw_new", dado_lido, 8'hAA);
    escrita_valida = 1; endereco_escrita = 1; dado_escrita = 8'h55; limpar = 1;
    #1;
    check("clr_pronta_low", escrita_pronta, 0);
    cyc(1, 1, 8'h55, 0, 0, 1);
    check("clr_ocupado_1", ocupado, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 3, 0);
    check("clr_read3_old", dado_lido, 8'h44);
    cyc(0, 0, 0, 1, 0, 0);
    check("clr_read0_new", dado_lido, CV);
    check("clr_ocupado_3", ocupado, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("clr_ocupado_end", ocupado, 0);
    for (int a = 0; a < 4; a++) begin
      cyc(0, 0, 0, 1, 2'(a), 0);
      check("clr_read_cv", dado_lido, CV);
    end
    cyc(1, 3, 8'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    check("midclr_pronta", escrita_pronta, 1);
    for (int a = 0; a < 4; a++) begin
      cyc(0, 0, 0, 1, 2'(a), 0);
      check("midclr_read0", dado_lido, 0);
    end
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
          1'($urandom), 2'($urandom), 1'($urandom_range(0, 15) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
